// File: rtl/dma_pkg.sv
`default_nettype none
// ============================================================================
// dma_pkg : shared constants and read-FSM state type for the DMA register port
// Revision: 1.0
// ============================================================================
package dma_pkg;

    localparam int NCH = 4;

    localparam logic [3:0] ADDR_CH0 = 4'h0;
    localparam logic [3:0] WORD_CH0 = 4'h1;
    localparam logic [3:0] ADDR_CH1 = 4'h2;
    localparam logic [3:0] WORD_CH1 = 4'h3;
    localparam logic [3:0] ADDR_CH2 = 4'h4;
    localparam logic [3:0] WORD_CH2 = 4'h5;
    localparam logic [3:0] ADDR_CH3 = 4'h6;
    localparam logic [3:0] WORD_CH3 = 4'h7;
    localparam logic [3:0] STATUS   = 4'h8;
    localparam logic [3:0] CLR_FF   = 4'hC;
    localparam logic [3:0] TEMP     = 4'hD;
    localparam logic [3:0] MCLR     = 4'hD;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LATCH   = 2'd1,
        DRIVE   = 2'd2,
        RELEASE = 2'd3
    } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/dma_rd_mux.sv
`default_nettype none
// ============================================================================
// dma_rd_mux : combinational read-data select and address classification
// Revision: 1.0
// ============================================================================
module dma_rd_mux
    import dma_pkg::*;
#(
    parameter int NCH = dma_pkg::NCH
) (
    input  logic [3:0]        A,
    input  logic              ff,
    input  logic [NCH*16-1:0] cur_addr,
    input  logic [NCH*16-1:0] cur_word,
    input  logic [7:0]        status_in,
    input  logic [7:0]        temp_in,
    output logic [7:0]        data,
    output logic              mapped,
    output logic              is_addrword,
    output logic              is_status
);

    logic [1:0]  ch;
    logic [15:0] reg16;

    always_comb begin
        data        = 8'h00;
        mapped      = 1'b0;
        is_addrword = 1'b0;
        is_status   = 1'b0;
        ch          = A[2:1];
        reg16       = 16'h0000;

        // 0x0-0x7: even = address, odd = word count, channel in A[2:1]
        if (!A[3]) begin
            reg16       = A[0] ? cur_word[int'(ch)*16 +: 16]
                               : cur_addr[int'(ch)*16 +: 16];
            data        = ff ? reg16[15:8] : reg16[7:0];
            mapped      = 1'b1;
            is_addrword = 1'b1;
        end else if (A == STATUS) begin
            data      = status_in;
            mapped    = 1'b1;
            is_status = 1'b1;
        end else if (A == TEMP) begin
            data   = temp_in;
            mapped = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dma_reg_read_port.sv
`default_nettype none
// ============================================================================
// dma_reg_read_port : CPU register read-out path, byte-pointer FF, TC clear
// Revision: 1.0
// ============================================================================
module dma_reg_read_port
    import dma_pkg::*;
#(
    parameter int NCH    = dma_pkg::NCH,
    parameter int RD_LAT = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CS_N,
    input  logic              IOR_N,
    input  logic [3:0]        A,
    input  logic [NCH*16-1:0] cur_addr,
    input  logic [NCH*16-1:0] cur_word,
    input  logic [7:0]        status_in,
    input  logic [7:0]        temp_in,
    input  logic              ff_clear,
    input  logic              master_clear,
    input  logic              wr_ff_toggle,
    output logic [7:0]        DB_OUT,
    output logic              DB_OE,
    output logic              ff,
    output logic              tc_clr
);

    rd_state_t  state;
    rd_state_t  state_nx;

    logic       rd_active;
    logic       rd_hold;
    logic       cap_addrword;
    logic       cap_status;
    logic       rel_toggle;

    logic [7:0] mux_data;
    logic       mux_mapped;
    logic       mux_addrword;
    logic       mux_status;

    assign rd_active = !CS_N && !IOR_N;

    dma_rd_mux #(
        .NCH (NCH)
    ) u_mux (
        .A           (A),
        .ff          (ff),
        .cur_addr    (cur_addr),
        .cur_word    (cur_word),
        .status_in   (status_in),
        .temp_in     (temp_in),
        .data        (mux_data),
        .mapped      (mux_mapped),
        .is_addrword (mux_addrword),
        .is_status   (mux_status)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (rd_active && !rd_hold) state_nx = LATCH;
            LATCH:   state_nx = DRIVE;
            DRIVE:   if (!rd_active) state_nx = RELEASE;
            RELEASE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (master_clear) begin
            state_nx = IDLE;
        end
    end

    // rd_hold keeps an aborted access from restarting until the strobe drops
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            DB_OUT       <= 8'h00;
            DB_OE        <= 1'b0;
            cap_addrword <= 1'b0;
            cap_status   <= 1'b0;
            rd_hold      <= 1'b0;
        end else if (master_clear) begin
            DB_OUT       <= 8'h00;
            DB_OE        <= 1'b0;
            cap_addrword <= 1'b0;
            cap_status   <= 1'b0;
            rd_hold      <= rd_active;
        end else begin
            if (state == LATCH) begin
                DB_OUT       <= mux_data;
                DB_OE        <= mux_mapped;
                cap_addrword <= mux_addrword;
                cap_status   <= mux_status;
            end else if (state == DRIVE && !rd_active) begin
                DB_OE <= 1'b0;
            end
            if (!rd_active) begin
                rd_hold <= 1'b0;
            end
        end
    end

    assign rel_toggle = (state == RELEASE) && cap_addrword;
    assign tc_clr     = (state == RELEASE) && cap_status && !master_clear;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ff <= 1'b0;
        end else if (master_clear || ff_clear) begin
            ff <= 1'b0;
        end else if (rel_toggle || wr_ff_toggle) begin
            ff <= ~ff;
        end
    end

    // Simultaneous read- and write-side toggles collapse to a single flip
    a_toggle_collide: assert property (@(posedge CLK) disable iff (!RESET)
        !(rel_toggle && wr_ff_toggle));

    a_rd_lat: assert property (@(posedge CLK) RD_LAT == 1);

endmodule
`default_nettype wire

// File: tb/tb_dma_reg_read_port.sv
`default_nettype none
// ============================================================================
// tb_dma_reg_read_port : scoreboard bench for the DMA register read port
// Revision: 1.0
// ============================================================================
module tb_dma_reg_read_port;

    localparam int NCH = 4;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              CS_N;
    logic              IOR_N;
    logic [3:0]        A;
    logic [NCH*16-1:0] cur_addr;
    logic [NCH*16-1:0] cur_word;
    logic [7:0]        status_in;
    logic [7:0]        temp_in;
    logic              ff_clear;
    logic              master_clear;
    logic              wr_ff_toggle;
    logic [7:0]        DB_OUT;
    logic              DB_OE;
    logic              ff;
    logic              tc_clr;

    dma_reg_read_port #(.NCH(NCH), .RD_LAT(1)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .CS_N         (CS_N),
        .IOR_N        (IOR_N),
        .A            (A),
        .cur_addr     (cur_addr),
        .cur_word     (cur_word),
        .status_in    (status_in),
        .temp_in      (temp_in),
        .ff_clear     (ff_clear),
        .master_clear (master_clear),
        .wr_ff_toggle (wr_ff_toggle),
        .DB_OUT       (DB_OUT),
        .DB_OE        (DB_OE),
        .ff           (ff),
        .tc_clr       (tc_clr)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   tc_count = 0;
    int   oe_rises = 0;
    logic oe_q = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge CLK) cyc++;

    // Monitor: every DB_OE rise is one read result leaving the DUT
    always @(negedge CLK) begin
        if (tc_clr) tc_count++;
        if (DB_OE && !oe_q) begin
            oe_rises++;
            if (exp_q.size() == 0) begin
                check("oe_spurious", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rd_data", {24'h0, DB_OUT}, {24'h0, e.data});
                check("rd_lat", cyc, e.cyc);
            end
        end
        oe_q = DB_OE;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_ff_clear();
        ff_clear = 1'b1;
        step();
        ff_clear = 1'b0;
    endtask

    // Read with strobe low for 'hold' edges, then two edges for RELEASE/IDLE
    task automatic do_read(input logic [3:0] addr, input int hold,
                           input logic mapped, input logic [7:0] exp);
        exp_t e;
        step();
        if (mapped) begin
            e.data = exp;
            e.cyc  = cyc + 2;
            exp_q.push_back(e);
        end
        CS_N  = 1'b0;
        IOR_N = 1'b0;
        A     = addr;
        repeat (hold) @(posedge CLK);
        #1;
        CS_N  = 1'b1;
        IOR_N = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
    endtask

    initial begin
        int tc_base;
        int oe_base;
        exp_t e;

        RESET        = 1'b0;
        CS_N         = 1'b1;
        IOR_N        = 1'b1;
        A            = 4'h0;
        cur_addr     = '0;
        cur_word     = '0;
        status_in    = 8'h00;
        temp_in      = 8'h00;
        ff_clear     = 1'b0;
        master_clear = 1'b0;
        wr_ff_toggle = 1'b0;

        repeat (3) step();
        check("rst_db_out", {24'h0, DB_OUT}, 32'h0);
        check("rst_db_oe", {31'h0, DB_OE}, 32'h0);
        check("rst_ff", {31'h0, ff}, 32'h0);
        check("rst_tc_clr", {31'h0, tc_clr}, 32'h0);
        RESET = 1'b1;
        step();

        // Two reads of channel 2 address: low byte then high byte
        cur_addr[47:32] = 16'hA55A;
        do_read(4'h4, 3, 1'b1, 8'h5A);
        check("ff_after_rd1", {31'h0, ff}, 32'h1);
        do_read(4'h4, 3, 1'b1, 8'hA5);
        check("ff_after_rd2", {31'h0, ff}, 32'h0);

        // ff_clear, word count read, write-side toggle
        cur_word[31:16] = 16'h1234;
        pulse_ff_clear();
        check("ff_clear", {31'h0, ff}, 32'h0);
        do_read(4'h3, 2, 1'b1, 8'h34);
        check("ff_word_rd", {31'h0, ff}, 32'h1);
        wr_ff_toggle = 1'b1;
        step();
        wr_ff_toggle = 1'b0;
        check("ff_wr_toggle", {31'h0, ff}, 32'h0);
        do_read(4'h3, 2, 1'b1, 8'h34);
        check("ff_word_rd2", {31'h0, ff}, 32'h1);

        // Status read: one tc_clr pulse, ff untouched
        status_in = 8'h25;
        tc_base   = tc_count;
        do_read(4'h8, 3, 1'b1, 8'h25);
        check("tc_pulses", tc_count - tc_base, 32'd1);
        check("ff_status", {31'h0, ff}, 32'h1);

        // Unmapped read held 5 cycles
        tc_base = tc_count;
        oe_base = oe_rises;
        do_read(4'hF, 5, 1'b0, 8'h00);
        check("unmap_oe", oe_rises - oe_base, 32'd0);
        check("unmap_tc", tc_count - tc_base, 32'd0);
        check("unmap_ff", {31'h0, ff}, 32'h1);

        // Temporary register
        temp_in = 8'hC3;
        do_read(4'hD, 2, 1'b1, 8'hC3);
        check("temp_ff", {31'h0, ff}, 32'h1);

        // Source and address change mid-read do not alter DB_OUT
        pulse_ff_clear();
        cur_addr[15:0] = 16'h00FF;
        e.data = 8'hFF;
        e.cyc  = cyc + 2;
        exp_q.push_back(e);
        CS_N  = 1'b0;
        IOR_N = 1'b0;
        A     = 4'h0;
        step();
        step();
        cur_addr[15:0] = 16'h0000;
        A = 4'h8;
        step();
        check("frozen_db", {24'h0, DB_OUT}, 32'hFF);
        check("frozen_oe", {31'h0, DB_OE}, 32'h1);
        CS_N  = 1'b1;
        IOR_N = 1'b1;
        step();
        step();
        check("ff_frozen_rd", {31'h0, ff}, 32'h1);

        // master_clear during DRIVE of a status read
        tc_base = tc_count;
        e.data = 8'h25;
        e.cyc  = cyc + 2;
        exp_q.push_back(e);
        CS_N  = 1'b0;
        IOR_N = 1'b0;
        A     = 4'h8;
        step();
        step();
        step();
        master_clear = 1'b1;
        step();
        master_clear = 1'b0;
        check("mclr_oe", {31'h0, DB_OE}, 32'h0);
        check("mclr_db", {24'h0, DB_OUT}, 32'h0);
        check("mclr_ff", {31'h0, ff}, 32'h0);
        step();
        step();
        check("mclr_hold_oe", {31'h0, DB_OE}, 32'h0);
        CS_N  = 1'b1;
        IOR_N = 1'b1;
        repeat (3) step();
        check("mclr_tc", tc_count - tc_base, 32'd0);
        check("mclr_ff_end", {31'h0, ff}, 32'h0);

        // Reset asserted mid-read
        cur_word[15:0] = 16'hBEEF;
        tc_base = tc_count;
        e.data = 8'hEF;
        e.cyc  = cyc + 2;
        exp_q.push_back(e);
        CS_N  = 1'b0;
        IOR_N = 1'b0;
        A     = 4'h1;
        step();
        step();
        step();
        RESET = 1'b0;
        #1;
        check("arst_oe", {31'h0, DB_OE}, 32'h0);
        check("arst_db", {24'h0, DB_OUT}, 32'h0);
        check("arst_ff", {31'h0, ff}, 32'h0);
        check("arst_tc", {31'h0, tc_clr}, 32'h0);
        CS_N  = 1'b1;
        IOR_N = 1'b1;
        step();
        RESET = 1'b1;
        repeat (3) step();
        check("arst_ff_end", {31'h0, ff}, 32'h0);
        check("arst_tc_cnt", tc_count - tc_base, 32'd0);

        // Recovery read of channel 3 address, low byte
        cur_addr[63:48] = 16'h7E81;
        do_read(4'h6, 2, 1'b1, 8'h81);
        check("recov_ff", {31'h0, ff}, 32'h1);

        step();
        check("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dma_reg_read_port.md
Name: dma_reg_read_port

Overview:
- CPU-side register read-out path of the 8237A-style DMA controller; the read counterpart of the register write path that loads base/current/mode/command registers from the I/O data buffer.
- Decodes CPU I/O reads (CS_N/IOR_N/A[3:0]) and returns current address, current word count, status or temporary register bytes on the data bus.
- Owns the byte-pointer flip-flop (FF) shared with the write path; generates the status-read side effect (TC bit clear).

Parameters:
- NCH, 4, number of DMA channels; register address map fixed for 4.
- RD_LAT, 1, cycles from read detection to DB_OE assertion; only 1 supported.

Ports:
- CLK  input  1  system clock
- RESET  input  1  asynchronous, active-low reset
- CS_N  input  1  chip select, active low, synchronous to CLK
- IOR_N  input  1  I/O read strobe, active low, synchronous to CLK
- A  input  4  I/O register address
- cur_addr  input  NCH*16  current address registers, channel n at [16n+15:16n]
- cur_word  input  NCH*16  current word count registers, same packing
- status_in  input  8  status: [3:0] TC reached per channel, [7:4] request pending
- temp_in  input  8  temporary register
- ff_clear  input  1  write-path pulse: clear byte pointer (write to 0xC)
- master_clear  input  1  write-path pulse: master clear (write to 0xD)
- wr_ff_toggle  input  1  write-path pulse: completed write to address/word register (0x0-0x7)
- DB_OUT  output  8  read data to CPU
- DB_OE  output  1  data bus drive enable
- ff  output  1  byte pointer: 0 = low byte, 1 = high byte
- tc_clr  output  1  one-cycle pulse: clear status_in[3:0] in the status register owner

Behaviour:
- Reset (RESET=0, async): state IDLE, DB_OUT=8'h00, DB_OE=0, ff=0, tc_clr=0.
- rd_active = !CS_N && !IOR_N. Address map: 0x0/2/4/6 = cur_addr ch0-3; 0x1/3/5/7 = cur_word ch0-3; 0x8 = status; 0xD = temp; all others unmapped.
- Byte select for address/word reads: ff=0 -> [7:0], ff=1 -> [15:8].
- FSM:
  - IDLE: rd_active -> LATCH.
  - LATCH (1 cycle): capture A and the mux result into DB_OUT -> DRIVE.
  - DRIVE: DB_OE=1 if captured address is mapped, else 0; stay while rd_active; !rd_active -> RELEASE.
  - RELEASE (1 cycle): DB_OE=0; apply side effect by captured address -> IDLE.
- DB_OE asserts on the 2nd rising edge after rd_active is first sampled (RD_LAT=1). DB_OUT is frozen from LATCH through RELEASE; A or source changes mid-read do not alter it.
- Side effects, in RELEASE only:
  - 0x0-0x7: ff toggles.
  - 0x8: tc_clr=1 for exactly one cycle.
  - 0xD or unmapped: none.
- FF priority per cycle: master_clear or ff_clear -> ff=0 (highest); else any of {RELEASE toggle, wr_ff_toggle} -> ff inverts once. If both toggles coincide, ff inverts once and a simulation assertion fires.
- master_clear in any state: abort to IDLE, DB_OE=0, DB_OUT=0, no side effect, tc_clr=0.
- rd_active held continuously: one access only. A new access requires rd_active to go low and then high again, passing through RELEASE and IDLE.
- RESET mid-read: immediate return to reset values; no tc_clr, no ff toggle.

Decomposition:
- dma_pkg: register address constants (ADDR_CH0..CH3, WORD_CH0..CH3, STATUS=4'h8, TEMP=4'hD, CLR_FF=4'hC, MCLR=4'hD), read FSM state enum (IDLE, LATCH, DRIVE, RELEASE), NCH.
- Sub-module dma_rd_mux: combinational select of {A, ff, cur_addr, cur_word, status_in, temp_in} -> {data[7:0], mapped, is_addrword, is_status}. FSM and FF stay in the top module.

Test Plan:
- ff=0, cur_addr ch2=16'hA55A; two reads at A=4 -> DB_OUT 8'h5A then 8'hA5; ff 0->1->0; DB_OE high 2 cycles after each read start.
- ff_clear pulse, then read A=3 with cur_word ch1=16'h1234 -> 8'h34, ff=1; wr_ff_toggle pulse -> ff=0; next read A=3 -> 8'h34.
- status_in=8'h25; read A=8 -> DB_OUT 8'h25; tc_clr single pulse in RELEASE; ff unchanged.
- Read A=4'hF (unmapped), IOR_N low 5 cycles -> DB_OE stays 0, no tc_clr, ff unchanged; FSM returns to IDLE.
- Read A=0 with cur_addr ch0=16'h00FF; change cur_addr to 16'h0000 during DRIVE -> DB_OUT stays 8'hFF.
- master_clear during DRIVE of an A=8 read -> DB_OE=0 next cycle, no tc_clr, ff=0. Separately, RESET low mid-read -> all outputs return to reset values.
